// File: rtl/ahblite_waitstate_ram.sv
// AHB-Lite on-chip RAM slave with WAIT_STATES wait cycles per data phase.
// Define AHBLITE_RAM_ERR_EN to reject misaligned/oversize transfers with a two-cycle ERROR response.
//   state  | meaning
//   IDLE   | no data phase in progress
//   DATA   | data phase, stalls while the wait counter is non-zero
//   ERR1   | first ERROR cycle (HREADYOUT low)
//   ERR2   | second ERROR cycle (HREADYOUT high, next transfer may be accepted)
module ahblite_waitstate_ram #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic [3:0]  HPROT,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP
);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_e;

    state_e                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [1:0]            lo_q, lo_d;
    logic [2:0]            size_q, size_d;
    logic                  write_q, write_d;

    logic [31:0] mem [2**ADDR_WIDTH];

    logic       accept;
    logic       illegal;
    logic       take;
    logic       mem_we;
    logic [3:0] lane_en;
    logic       unused_bits;

    assign unused_bits = ^{HPROT, HADDR[31:ADDR_WIDTH+2]};
    assign accept      = HSEL & HTRANS[1] & HREADY;

`ifdef AHBLITE_RAM_ERR_EN
    assign illegal = (HSIZE > 3'd2)
                   | ((HSIZE == 3'd1) & HADDR[0])
                   | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));
    assign HRESP   = (state_q == S_ERR1) | (state_q == S_ERR2);
`else
    assign illegal = 1'b0;
    assign HRESP   = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        waddr_d   = waddr_q;
        lo_d      = lo_q;
        size_d    = size_q;
        write_d   = write_q;
        HREADYOUT = 1'b1;
        take      = 1'b0;
        case (state_q)
            S_IDLE: take = 1'b1;
            S_DATA: begin
                HREADYOUT = (cnt_q == 3'd0);
                if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
                else               take  = 1'b1;
            end
`ifdef AHBLITE_RAM_ERR_EN
            S_ERR1: begin
                HREADYOUT = 1'b0;
                state_d   = S_ERR2;
            end
            S_ERR2: take = 1'b1;
`endif
            default: state_d = S_IDLE;
        endcase
        if (take) begin
            state_d = S_IDLE;
            if (accept) begin
                waddr_d = HADDR[ADDR_WIDTH+1:2];
                lo_d    = HADDR[1:0];
                size_d  = HSIZE;
                write_d = HWRITE;
                if (illegal) begin
                    state_d = S_ERR1;
                end else begin
                    state_d = S_DATA;
                    cnt_d   = 3'(WAIT_STATES);
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            waddr_q <= '0;
            lo_q    <= 2'd0;
            size_q  <= 3'd0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            waddr_q <= waddr_d;
            lo_q    <= lo_d;
            size_q  <= size_d;
            write_q <= write_d;
        end
    end

    // Oversize transfers act as words; misaligned ones fall on the aligned lanes.
    always_comb begin
        lane_en = 4'b0000;
        case (size_q)
            3'd0:    lane_en = 4'b0001 << lo_q;
            3'd1:    lane_en = lo_q[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    end

    assign mem_we = (state_q == S_DATA) & (cnt_q == 3'd0) & write_q;

    always_ff @(posedge HCLK) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) mem[waddr_q][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    assign HRDATA = ((state_q == S_DATA) && !write_q) ? mem[waddr_q] : 32'h0;

endmodule

// File: tb/tb_ahblite_waitstate_ram.sv
// Bench for ahblite_waitstate_ram: three instances (WAIT_STATES 1, 0, 3) checked per cycle against a byte-lane RAM model.
module tb_ahblite_waitstate_ram;

    localparam int ND = 3;
    localparam int WS_TAB [ND] = '{1, 0, 3};
`ifdef AHBLITE_RAM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    logic        clk = 1'b0;
    logic        rst_n     [ND];
    logic        hsel      [ND];
    logic [31:0] haddr     [ND];
    logic [1:0]  htrans    [ND];
    logic [2:0]  hsize     [ND];
    logic [3:0]  hprot     [ND];
    logic        hwrite    [ND];
    logic [31:0] hwdata    [ND];
    logic        hready    [ND];
    logic        ext_rdy   [ND];
    logic        hreadyout [ND];
    logic [31:0] hrdata    [ND];
    logic        hresp     [ND];

    logic [31:0] ref_mem [ND][1024];
    xfer_t       bq [$];
    logic [31:0] last_rd;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        assign hready[g] = hreadyout[g] & ext_rdy[g];
        ahblite_waitstate_ram #(.ADDR_WIDTH(10), .WAIT_STATES(WS_TAB[g])) dut (
            .HCLK(clk), .HRESETn(rst_n[g]), .HSEL(hsel[g]), .HADDR(haddr[g]),
            .HTRANS(htrans[g]), .HSIZE(hsize[g]), .HPROT(hprot[g]), .HWRITE(hwrite[g]),
            .HWDATA(hwdata[g]), .HREADY(hready[g]), .HREADYOUT(hreadyout[g]),
            .HRDATA(hrdata[g]), .HRESP(hresp[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic xfer_t mk(input logic wr, input logic [31:0] addr,
                                 input logic [2:0] size, input logic [31:0] wdata);
        xfer_t t;
        t.wr = wr; t.addr = addr; t.size = size; t.wdata = wdata;
        return t;
    endfunction

    function automatic int widx(input logic [31:0] addr);
        return int'((addr >> 2) & 32'h3FF);
    endfunction

    function automatic bit is_illegal(input xfer_t t);
        return (t.size > 3'd2) || (t.size == 3'd1 && t.addr[0]) ||
               (t.size == 3'd2 && t.addr[1:0] != 2'b00);
    endfunction

    // Reference write: a transfer of 2^size bytes (capped at 4) starting at the size-aligned byte.
    function automatic void model_write(input int d, input xfer_t t);
        int nb   = 1 << ((t.size > 3'd2) ? 2 : int'(t.size));
        int base = int'(t.addr[1:0]) & ~(nb - 1);
        int w    = widx(t.addr);
        for (int b = base; b < base + nb; b++) ref_mem[d][w][8*b +: 8] = t.wdata[8*b +: 8];
    endfunction

    task automatic idle_cycle(input int d, input string tag);
        @(negedge clk);
        chk($sformatf("%s_rdy_d%0d", tag, d), 32'(hreadyout[d]), 32'd1);
        chk($sformatf("%s_resp_d%0d", tag, d), 32'(hresp[d]), 32'd0);
        @(posedge clk); #1;
    endtask

    // Pipelined driver for the transfers in bq; called and returning just after a rising edge.
    task automatic run_burst(input int d);
        int ap = 0, dp = -1, k = 0, guard = 0;
        logic rdy, rsp, ill, exp_rdy, exp_rsp;
        logic [31:0] rd, exp_rd;
        last_rd = 32'h0;
        while ((ap < bq.size() || dp >= 0) && guard < 100) begin
            guard++;
            if (ap < bq.size()) begin
                hsel[d] = 1'b1; htrans[d] = 2'b10 | 2'($urandom_range(0, 1));
                haddr[d] = bq[ap].addr; hwrite[d] = bq[ap].wr; hsize[d] = bq[ap].size;
            end else begin
                hsel[d] = 1'b0; htrans[d] = 2'b00;
            end
            hwdata[d] = (dp >= 0) ? bq[dp].wdata : $urandom;
            @(negedge clk);
            rdy = hreadyout[d]; rsp = hresp[d]; rd = hrdata[d];
            if (dp < 0) begin
                exp_rdy = 1'b1; exp_rsp = 1'b0; exp_rd = 32'h0; ill = 1'b0;
            end else begin
                ill = ERR_EN && is_illegal(bq[dp]);
                if (ill) begin
                    exp_rdy = (k == 1); exp_rsp = 1'b1; exp_rd = 32'h0;
                end else begin
                    exp_rdy = (k == WS_TAB[d]); exp_rsp = 1'b0;
                    exp_rd  = bq[dp].wr ? 32'h0 : ref_mem[d][widx(bq[dp].addr)];
                end
            end
            chk($sformatf("rdy_d%0d_k%0d", d, k), 32'(rdy), 32'(exp_rdy));
            chk($sformatf("resp_d%0d_k%0d", d, k), 32'(rsp), 32'(exp_rsp));
            chk($sformatf("rdata_d%0d_k%0d", d, k), rd, exp_rd);
            if (dp >= 0 && rdy) begin
                if (bq[dp].wr && !ill) model_write(d, bq[dp]);
                if (!bq[dp].wr) last_rd = rd;
            end
            @(posedge clk); #1;
            if (rdy) begin
                k  = 0;
                dp = (ap < bq.size()) ? ap : -1;
                if (ap < bq.size()) ap++;
            end else begin
                k++;
            end
        end
        chk($sformatf("burst_bound_d%0d", d), 32'(guard < 100), 32'd1);
    endtask

    task automatic reset_mid(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        hsel[d] = 1'b1; htrans[d] = 2'b10; haddr[d] = addr; hwrite[d] = wr; hsize[d] = 3'd2;
        @(negedge clk);
        chk("rstmid_accept_rdy", 32'(hreadyout[d]), 32'd1);
        @(posedge clk); #1;
        hsel[d] = 1'b0; htrans[d] = 2'b00; hwdata[d] = wdata;
        @(negedge clk);
        chk("rstmid_wait1_rdy", 32'(hreadyout[d]), 32'd0);
        chk("rstmid_wait1_rdata", hrdata[d], wr ? 32'h0 : ref_mem[d][widx(addr)]);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstmid_wait2_rdy", 32'(hreadyout[d]), 32'd0);
        rst_n[d] = 1'b0;
        #1;
        chk("rstmid_rdy", 32'(hreadyout[d]), 32'd1);
        chk("rstmid_resp", 32'(hresp[d]), 32'd0);
        chk("rstmid_rdata", hrdata[d], 32'h0);
        @(posedge clk); #1;
        rst_n[d] = 1'b1;
    endtask

    initial begin
        for (int d = 0; d < ND; d++) begin
            rst_n[d] = 1'b0; hsel[d] = 1'b0; haddr[d] = 32'h0; htrans[d] = 2'b00;
            hsize[d] = 3'd0; hprot[d] = 4'h3; hwrite[d] = 1'b0; hwdata[d] = 32'h0; ext_rdy[d] = 1'b1;
        end
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("reset_rdy_d%0d", d), 32'(hreadyout[d]), 32'd1);
            chk($sformatf("reset_resp_d%0d", d), 32'(hresp[d]), 32'd0);
            chk($sformatf("reset_rdata_d%0d", d), hrdata[d], 32'h0);
        end
        @(posedge clk); #1;
        for (int d = 0; d < ND; d++) rst_n[d] = 1'b1;

        // WAIT_STATES=1: word, byte and halfword writes read back as words
        bq.delete(); bq.push_back(mk(1, 32'h10, 3'd2, 32'hDEADBEEF)); bq.push_back(mk(0, 32'h10, 3'd2, 32'h0));
        run_burst(0);
        chk("word_rd", last_rd, 32'hDEADBEEF);
        bq.delete(); bq.push_back(mk(1, 32'h13, 3'd0, 32'hAA000000)); bq.push_back(mk(0, 32'h10, 3'd2, 32'h0));
        run_burst(0);
        chk("byte_rd", last_rd, 32'hAAADBEEF);
        bq.delete(); bq.push_back(mk(1, 32'h10, 3'd1, 32'h00001234)); bq.push_back(mk(0, 32'h10, 3'd2, 32'h0));
        run_burst(0);
        chk("half_rd", last_rd, 32'hAAAD1234);

        // unselected, IDLE and HREADY-low cycles must not start a transfer
        hwrite[0] = 1'b1; haddr[0] = 32'h10; hsize[0] = 3'd2; hwdata[0] = 32'hFFFFFFFF;
        hsel[0] = 1'b0; htrans[0] = 2'b10;
        idle_cycle(0, "nosel");
        hsel[0] = 1'b1; htrans[0] = 2'b00;
        idle_cycle(0, "idle_trans");
        htrans[0] = 2'b10; ext_rdy[0] = 1'b0;
        idle_cycle(0, "hready_low");
        ext_rdy[0] = 1'b1; hsel[0] = 1'b0; htrans[0] = 2'b00;
        idle_cycle(0, "after_hready_low");
        bq.delete(); bq.push_back(mk(0, 32'h10, 3'd2, 32'h0));
        run_burst(0);
        chk("noaccess_rd", last_rd, 32'hAAAD1234);

        // misaligned word write: ERROR response or forced alignment depending on build
        bq.delete(); bq.push_back(mk(1, 32'h12, 3'd2, 32'h11223344)); bq.push_back(mk(0, 32'h10, 3'd2, 32'h0));
        run_burst(0);
        chk("misaligned_rd", last_rd, ERR_EN ? 32'hAAAD1234 : 32'h11223344);

        // WAIT_STATES=0: pipelined write then read of the same word
        bq.delete(); bq.push_back(mk(1, 32'h20, 3'd2, 32'h5)); bq.push_back(mk(0, 32'h20, 3'd2, 32'h0));
        run_burst(1);
        chk("zero_wait_rd", last_rd, 32'h00000005);

        // WAIT_STATES=3: reset during the second wait cycle drops the write
        bq.delete(); bq.push_back(mk(1, 32'h40, 3'd2, 32'h13579BDF));
        run_burst(2);
        reset_mid(2, 1'b1, 32'h40, 32'h0BADF00D);
        bq.delete(); bq.push_back(mk(0, 32'h40, 3'd2, 32'h0));
        run_burst(2);
        chk("rstmid_wr_dropped", last_rd, 32'h13579BDF);
        reset_mid(2, 1'b0, 32'h40, 32'h0);

        // randomized bursts over a pre-initialised pool of words on every instance
        for (int d = 0; d < ND; d++) begin
            bq.delete();
            for (int i = 0; i < 8; i++) bq.push_back(mk(1, 32'h100 + 32'(4 * i), 3'd2, $urandom));
            run_burst(d);
            for (int b = 0; b < 5; b++) begin
                bq.delete();
                for (int i = 0; i < int'($urandom_range(1, 6)); i++)
                    bq.push_back(mk(1'($urandom_range(0, 1)),
                                    32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3)),
                                    3'($urandom_range(0, 4)), $urandom));
                run_burst(d);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ahblite_waitstate_ram.md
# ahblite_waitstate_ram

AHB-Lite slave (responder) that sits on one peripheral port of the AHB-Lite interconnect and serves as an on-chip RAM with a programmable number of wait states. It samples address-phase controls, inserts a fixed wait-state count, and performs byte, halfword and word writes and word reads. With the error option compiled in, it rejects misaligned or oversize transfers with the two-cycle AHB ERROR response.

## Interface
- ADDR_WIDTH, 10: word-address bits; capacity is 2^ADDR_WIDTH 32-bit words, addressed by HADDR[ADDR_WIDTH+1:2].
- WAIT_STATES, 1: wait cycles per data phase, range 0..7.

- HCLK  in  1  clock. One clock domain.
- HRESETn  in  1  reset, asynchronous and active-low.
- HSEL  in  1  slave select from the decoder.
- HADDR  in  32  address.
- HTRANS  in  2  transfer type.
- HSIZE  in  3  transfer size.
- HPROT  in  4  ignored.
- HWRITE  in  1  write when 1.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus ready from the slave multiplexer.
- HREADYOUT  out  1  this slave's ready.
- HRDATA  out  32  read data.
- HRESP  out  1  0 = OKAY, 1 = ERROR.

## Operation
- Accept: HSEL & HTRANS[1] & HREADY, sampled at the rising edge. At accept, latch the word address, HADDR[1:0], HSIZE and HWRITE.
- IDLE/BUSY transfers and unselected cycles produce no action and leave HREADYOUT=1 and HRESP=0.
- State machine:
  - **IDLE** → DATA on an accept. If the transfer is illegal and AHBLITE_RAM_ERR_EN is defined, IDLE → ERR1 instead.
  - **DATA**: the wait counter loads WAIT_STATES at accept. HREADYOUT = (cnt==0). While cnt≠0, cnt decrements each cycle.
  - At the edge where cnt==0 the data phase completes. A write is committed at that edge. The next state is DATA or ERR1 on a new accept, otherwise IDLE.
  - **ERR1**: HRESP=1, HREADYOUT=0. Always goes to ERR2.
  - **ERR2**: HRESP=1, HREADYOUT=1. Goes to DATA, ERR1 or IDLE according to a new accept, as for DATA.
- Writes use little-endian byte lanes. The lane is selected by the latched HADDR[1:0] and HSIZE:
  - byte: 1 lane;
  - halfword: lanes {1:0} or {3:2};
  - word: all 4 lanes.
  - Unselected lanes are unchanged. HWDATA is taken from the matching lanes.
- Reads: HRDATA = mem[latched word address] during a read in DATA, otherwise 0. HRDATA is read combinationally from the array, so a read whose address phase overlaps the completing write sees the new data.
- Memory contents are not reset.

## Timing
- Reset values: state=IDLE, cnt=0, HREADYOUT=1, HRESP=0, HRDATA=0, latched address/size/write=0.
- Latency: a data phase lasts WAIT_STATES+1 cycles. WAIT_STATES=0 gives zero-wait transfers.
- Back-to-back transfers are pipelined. The address phase of transfer N+1 is accepted in the completing cycle of transfer N, with no bubble.
- If HRESETn asserts mid-transfer, all outputs immediately take their reset values. A pending write is dropped.
- While HREADY is low because another slave is stalling, no accept occurs.

## Configuration
- AHBLITE_RAM_ERR_EN defined:
  - Illegal transfers are halfword with HADDR[0]=1, word with HADDR[1:0]≠0, and HSIZE>2.
  - They take ERR1 then ERR2. There is no memory write, HRDATA=0, and wait states do not apply.
- Not defined:
  - HRESP is tied to 0 and ERR states are absent.
  - Misaligned addresses are force-aligned by clearing the low bits for the given size.
  - HSIZE>2 is treated as a word transfer.

## Test plan
- WAIT_STATES=1: word write 0xDEADBEEF to 0x10, then word read 0x10 → HREADYOUT low 1 cycle in each data phase; HRDATA=0xDEADBEEF; HRESP=0.
- Byte write 0xAA to 0x13, then word read 0x10 → HRDATA=0xAAADBEEF. Then halfword write 0x1234 to 0x10 → read gives 0xAAAD1234.
- WAIT_STATES=0: pipelined write 0x5 to 0x20 immediately followed by a read of 0x20 → HREADYOUT stays 1 throughout; read returns 0x00000005.
- With AHBLITE_RAM_ERR_EN: word write to 0x12 → cycle 1 HRESP=1/HREADYOUT=0, cycle 2 HRESP=1/HREADYOUT=1; word 0x10 unchanged. Without the macro, the same write lands at 0x10.
- WAIT_STATES=3: HRESETn pulsed low during the second wait cycle → HREADYOUT=1, HRESP=0, HRDATA=0 immediately; the write is not committed.
- HSEL=0 with HTRANS=NONSEQ, then HSEL=1 with HTRANS=IDLE, both with HWRITE=1 → HREADYOUT stays 1 and the memory is unchanged.
